// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package display_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Host-side and display-side signals of the scan controller, bundled as one port.
interface display_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  localparam int IW = $clog2(N_DIGITS);

  logic                                   en_i;
  logic [display_pkg::DIGIT_W*N_DIGITS-1:0] value_i;
  logic                                   load_i;
  logic [N_DIGITS-1:0]                    digit_en_i;
  logic [display_pkg::DIGIT_W-1:0]        bcd_o;
  logic [N_DIGITS-1:0]                    an_o;
  logic [IW-1:0]                          digit_idx_o;
  logic                                   frame_o;
  logic                                   pending_o;

  modport master (
    output en_i, value_i, load_i, digit_en_i,
    input  bcd_o, an_o, digit_idx_o, frame_o, pending_o
  );

  modport slave (
    input  en_i, value_i, load_i, digit_en_i,
    output bcd_o, an_o, digit_idx_o, frame_o, pending_o
  );
endinterface

// File: rtl/scan_timer.sv
// Slot duration counter: restarts from zero on clr_i, flags the cycle whose count equals last_i.
module scan_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scanner with blank/show slots and frame-synchronous double-buffered values.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  display_scan_ctrl_if.slave bus
);

  localparam int IW   = $clog2(N_DIGITS);
  localparam int MAXA = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int MAXL = (MAXA > 2) ? MAXA : 2;
  localparam int CW   = $clog2(MAXL);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_DIGITS - 1);

  typedef logic [N_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  scan_state_t         state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  digits_t             act_q, act_d, pbuf_q, pbuf_d;
  logic                pend_q, pend_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [DIGIT_W-1:0]  bcd_q, bcd_d;
  logic                frame_q;
  logic                clr, wrap, tc, commit_win;
  logic [CW-1:0]       last;

  assign last = (state_q == BLANK) ? BLANK_LAST : SHOW_LAST;

  scan_timer #(.W(CW)) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .last_i (last),
    .tc_o   (tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    wrap    = 1'b0;
    if (!bus.en_i) begin
      state_d = IDLE;
      idx_d   = '0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = HAS_BLANK ? BLANK : SHOW;
          idx_d   = '0;
          clr     = 1'b1;
        end
        BLANK: begin
          if (tc) begin
            state_d = SHOW;
            clr     = 1'b1;
          end
        end
        SHOW: begin
          if (tc) begin
            state_d = HAS_BLANK ? BLANK : SHOW;
            clr     = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          clr     = 1'b1;
        end
      endcase
    end

    // Values may only reach the active buffer where no frame is in progress.
    commit_win = wrap || (state_q == IDLE) || !bus.en_i;
    act_d  = act_q;
    pbuf_d = pbuf_q;
    pend_d = pend_q;
    if (bus.load_i) begin
      if (commit_win) begin
        act_d  = digits_t'(bus.value_i);
        pend_d = 1'b0;
      end else begin
        pbuf_d = digits_t'(bus.value_i);
        pend_d = 1'b1;
      end
    end else if (commit_win && pend_q) begin
      act_d  = pbuf_q;
      pend_d = 1'b0;
    end

    an_d = '0;
    if (state_d == SHOW && bus.digit_en_i[idx_d]) begin
      an_d[idx_d] = 1'b1;
    end
    bcd_d = act_d[idx_d];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      act_q   <= '0;
      pbuf_q  <= '0;
      pend_q  <= 1'b0;
      an_q    <= '0;
      bcd_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      pbuf_q  <= pbuf_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
      frame_q <= wrap;
    end
  end

  assign bus.an_o        = an_q;
  assign bus.bcd_o       = bcd_q;
  assign bus.digit_idx_o = idx_q;
  assign bus.frame_o     = frame_q;
  assign bus.pending_o   = pend_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: slot-arithmetic reference model plus directed and random scenarios.
module tb_display_scan_ctrl;

  localparam int ND  = 4;
  localparam int RD  = 4;
  localparam int BLK = 2;
  localparam int SL  = BLK + RD;
  localparam int FP  = ND * SL;

  logic clk;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  display_scan_ctrl_if #(.N_DIGITS(ND)) bus ();

  display_scan_ctrl #(
    .N_DIGITS     (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: position inside the frame is derived from time since scan start.
  bit          m_run;
  int          m_t;
  logic [15:0] m_act, m_pbuf;
  logic        m_pend, m_frame;
  logic [3:0]  m_an, m_bcd;
  logic [1:0]  m_idx;

  logic [11:0] got, expv;
  assign got  = {bus.an_o, bus.bcd_o, bus.digit_idx_o, bus.frame_o, bus.pending_o};
  assign expv = {m_an, m_bcd, m_idx, m_frame, m_pend};

  task automatic model_reset();
    m_run = 0; m_t = 0; m_act = '0; m_pbuf = '0; m_pend = 0;
    m_frame = 0; m_an = '0; m_bcd = '0; m_idx = '0;
  endtask

  task automatic tick();
    logic en_s, ld_s, cw;
    logic [15:0] v_s;
    logic [3:0] de_s;
    int p, d;
    en_s = bus.en_i; ld_s = bus.load_i; v_s = bus.value_i; de_s = bus.digit_en_i;
    @(posedge clk);
    cyc++;
    m_frame = 0;
    if (!en_s) begin
      cw = 1; m_run = 0; m_t = 0;
    end else if (!m_run) begin
      cw = 1; m_run = 1; m_t = 0;
    end else begin
      cw = ((m_t % FP) == FP - 1);
      m_frame = cw;
      m_t++;
    end
    if (ld_s) begin
      if (cw) begin m_act = v_s; m_pend = 0; end
      else begin m_pbuf = v_s; m_pend = 1; end
    end else if (cw && m_pend) begin
      m_act = m_pbuf; m_pend = 0;
    end
    m_an = '0; m_idx = '0;
    if (m_run) begin
      p = m_t % FP;
      d = p / SL;
      m_idx = d[1:0];
      if ((p % SL) >= BLK && de_s[d]) m_an = 4'(1 << d);
    end
    m_bcd = m_act[m_idx*4 +: 4];
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    bus.en_i = 0; bus.load_i = 0; bus.value_i = '0; bus.digit_en_i = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL reset_hold got=%h exp=000", got); end
    bus.en_i = 1; bus.load_i = 1; bus.value_i = 16'hFFFF;
    @(posedge clk); #1;
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL reset_ignores_inputs got=%h exp=000", got); end
    bus.en_i = 0; bus.load_i = 0;
    rst_ni = 1;
    model_reset();
    tick();
    checks++;
    if (got !== expv) begin errors++; $display("FAIL reset_idle got=%h exp=%h", got, expv); end
  endtask

  task automatic test_basic_scan();
    logic [15:0] lit = '0;
    int nfr = 0;
    bus.load_i = 1; bus.value_i = 16'h3A51;
    tick();
    bus.load_i = 0;
    checks++;
    if (got !== expv || bus.pending_o !== 1'b0) begin errors++; $display("FAIL idle_load got=%h exp=%h", got, expv); end
    bus.en_i = 1;
    tick();
    for (int i = 0; i < 2*FP; i++) begin
      checks++;
      if (got !== expv) begin errors++; $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, got, expv); end
      if (i < FP && bus.an_o != 0) lit[bus.digit_idx_o*4 +: 4] = bus.bcd_o;
      if (bus.frame_o) nfr++;
      if (i == FP) begin
        checks++;
        if (bus.frame_o !== 1'b1) begin errors++; $display("FAIL frame_at_24 got=%b exp=1", bus.frame_o); end
      end
      tick();
    end
    checks++;
    if (lit !== 16'h3A51) begin errors++; $display("FAIL basic_lit got=%h exp=3a51", lit); end
    checks++;
    if (nfr !== 1 || bus.frame_o !== 1'b1) begin errors++; $display("FAIL frame_period got=%0d/%b exp=1/1", nfr, bus.frame_o); end
  endtask

  task automatic test_pending_midframe();
    logic [15:0] lit = '0;
    int n = 0;
    while (!(bus.digit_idx_o == 2 && bus.an_o != 0) && n < 60) begin tick(); n++; end
    bus.load_i = 1; bus.value_i = 16'h1234;
    tick();
    bus.load_i = 0;
    checks++;
    if (bus.pending_o !== 1'b1 || n >= 60) begin errors++; $display("FAIL pend_set got=%b exp=1", bus.pending_o); end
    n = 0;
    while (!bus.frame_o && n < 40) begin
      checks++;
      if (got !== expv) begin errors++; $display("FAIL pend_wait cyc=%0d got=%h exp=%h", cyc, got, expv); end
      tick(); n++;
    end
    checks++;
    if (bus.pending_o !== 1'b0 || n >= 40) begin errors++; $display("FAIL pend_commit got=%b exp=0", bus.pending_o); end
    for (int i = 0; i < FP; i++) begin
      checks++;
      if (got !== expv) begin errors++; $display("FAIL pend_frame cyc=%0d got=%h exp=%h", cyc, got, expv); end
      if (bus.an_o != 0) lit[bus.digit_idx_o*4 +: 4] = bus.bcd_o;
      tick();
    end
    checks++;
    if (lit !== 16'h1234) begin errors++; $display("FAIL pend_lit got=%h exp=1234", lit); end
  endtask

  task automatic test_boundary_load();
    logic [15:0] lit = '0;
    int n = 0;
    while (!(m_run && (m_t % FP) == FP - 1) && n < 60) begin tick(); n++; end
    bus.load_i = 1; bus.value_i = 16'hBEEF;
    tick();
    bus.load_i = 0;
    for (int i = 0; i < FP; i++) begin
      checks++;
      if (got !== expv || bus.pending_o !== 1'b0) begin errors++; $display("FAIL boundary cyc=%0d got=%h exp=%h", cyc, got, expv); end
      if (bus.an_o != 0) lit[bus.digit_idx_o*4 +: 4] = bus.bcd_o;
      tick();
    end
    checks++;
    if (lit !== 16'hBEEF || n >= 60) begin errors++; $display("FAIL boundary_lit got=%h exp=beef", lit); end
  endtask

  task automatic test_digit_en();
    int n = 0, bad = 0;
    bus.digit_en_i = 4'b0111;
    while (!bus.frame_o && n < 60) begin tick(); n++; end
    for (int i = 0; i < FP; i++) begin
      checks++;
      if (got !== expv) begin errors++; $display("FAIL digit_en cyc=%0d got=%h exp=%h", cyc, got, expv); end
      if (bus.digit_idx_o == 3 && bus.an_o != 0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || bus.frame_o !== 1'b1 || n >= 60) begin errors++; $display("FAIL digit3_dark got=%0d/%b exp=0/1", bad, bus.frame_o); end
    bus.digit_en_i = 4'hF;
  endtask

  task automatic test_en_drop();
    int n = 0;
    while (!(bus.digit_idx_o == 2 && bus.an_o != 0) && n < 60) begin tick(); n++; end
    bus.en_i = 0;
    tick();
    checks++;
    if ({bus.an_o, bus.frame_o, bus.digit_idx_o} !== 7'b0 || n >= 60) begin errors++; $display("FAIL en_drop got=%b%b%b exp=0", bus.an_o, bus.frame_o, bus.digit_idx_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (got !== expv) begin errors++; $display("FAIL en_idle got=%h exp=%h", got, expv); end
    end
    bus.en_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.an_o !== ((i == 2) ? 4'b0001 : 4'b0000) || bus.digit_idx_o !== 2'd0) begin
        errors++; $display("FAIL restart%0d got=%b exp=%b", i, bus.an_o, (i == 2) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      bus.en_i       = ($urandom_range(0, 40) != 0);
      bus.load_i     = ($urandom_range(0, 12) == 0);
      bus.value_i    = 16'($urandom);
      bus.digit_en_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      tick();
      checks++;
      if (got !== expv) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, expv); end
    end
    bus.load_i = 0; bus.digit_en_i = 4'hF;
  endtask

  task automatic test_async_reset();
    int n = 0;
    bus.en_i = 1;
    while (!(bus.digit_idx_o == 1 && bus.an_o != 0) && n < 80) begin tick(); n++; end
    bus.load_i = 1; bus.value_i = 16'h5678;
    tick();
    bus.load_i = 0;
    n = 0;
    while (!(bus.digit_idx_o == 2 && bus.an_o != 0) && n < 40) begin tick(); n++; end
    checks++;
    if (bus.pending_o !== 1'b1 || n >= 40) begin errors++; $display("FAIL async_pre got=%b exp=1", bus.pending_o); end
    #2 rst_ni = 0;
    #1;
    checks++;
    if (got !== 12'h000) begin errors++; $display("FAIL async_reset got=%h exp=000", got); end
    @(posedge clk); #1;
    rst_ni = 1;
    model_reset();
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (got !== expv) begin errors++; $display("FAIL recover cyc=%0d got=%h exp=%h", cyc, got, expv); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_scan();
    test_pending_midframe();
    test_boundary_load();
    test_digit_en();
    test_en_drop();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
